// File: rtl/hsv_scene_sequencer.sv
// Autonomous HSV scene sequencer: fades the current colour one LSB per tick
// toward the active preset, dwells there, then advances to the next preset.
// Encoder activity pauses the sequence. Colour updates leave via valid/ready.
module hsv_scene_sequencer #(
   parameter int unsigned NUM_SCENES  = 4,
   parameter int unsigned CW          = 8,
   parameter int unsigned STEP_DIV    = 256,
   parameter int unsigned HOLD_TICKS  = 64,
   parameter int unsigned PAUSE_TICKS = 512,
   localparam int unsigned AW         = $clog2(NUM_SCENES)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            enable,
   input  logic            cfg_we,
   input  logic [AW-1:0]   cfg_addr,
   input  logic [3*CW-1:0] cfg_data,
   input  logic            manual_active,
   output logic [3*CW-1:0] hsv_out,
   output logic            hsv_valid,
   input  logic            hsv_ready,
   output logic [AW-1:0]   scene_idx,
   output logic            busy
);

   localparam int unsigned PW  = $clog2(STEP_DIV);
   localparam int unsigned HW  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam int unsigned PCW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

   // Half of the hue circle; differences up to and including this go upward.
   localparam logic [CW-1:0] HueHalf = {1'b1, {(CW-1){1'b0}}};

   typedef enum logic [1:0] {
      StIdle,
      StFade,
      StHold,
      StPause
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [PCW-1:0]  pause_cnt_q, pause_cnt_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   hue_q, hue_d;
   logic [CW-1:0]   sat_q, sat_d;
   logic [CW-1:0]   val_q, val_d;
   logic            valid_q, valid_d;
   logic [3*CW-1:0] table_q [NUM_SCENES];

   logic [3*CW-1:0] tgt;
   logic [CW-1:0]   tgt_hue, tgt_sat, tgt_val;
   logic [CW-1:0]   hue_diff;
   logic [CW-1:0]   hue_nxt, sat_nxt, val_nxt;
   logic            at_target;
   logic            tick;
   logic            blocked;
   logic            step_en;

   // Scene table: writes land at the edge, reads below see the old contents.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NUM_SCENES); i++) begin
            table_q[i] <= '0;
         end
      end else if (cfg_we) begin
         table_q[cfg_addr] <= cfg_data;
      end
   end

   // Live target lookup, so rewriting the active slot retargets a fade.
   assign tgt     = table_q[idx_q];
   assign tgt_hue = tgt[3*CW-1:2*CW];
   assign tgt_sat = tgt[2*CW-1:CW];
   assign tgt_val = tgt[CW-1:0];

   assign at_target = (tgt == {hue_q, sat_q, val_q});
   assign tick      = (state_q != StIdle) && (presc_q == PW'(STEP_DIV - 1));
   // A tick is lost while an earlier colour is still waiting for acceptance.
   assign blocked   = valid_q && !hsv_ready;

   // One-LSB step toward the target; hue takes the shorter way round the circle.
   always_comb begin
      hue_diff = tgt_hue - hue_q;
      hue_nxt  = hue_q;
      if (hue_diff != '0) begin
         if (hue_diff <= HueHalf) begin
            hue_nxt = hue_q + CW'(1);
         end else begin
            hue_nxt = hue_q - CW'(1);
         end
      end
      sat_nxt = sat_q;
      if (tgt_sat > sat_q) begin
         sat_nxt = sat_q + CW'(1);
      end else if (tgt_sat < sat_q) begin
         sat_nxt = sat_q - CW'(1);
      end
      val_nxt = val_q;
      if (tgt_val > val_q) begin
         val_nxt = val_q + CW'(1);
      end else if (tgt_val < val_q) begin
         val_nxt = val_q - CW'(1);
      end
   end

   // Prescaler: free-runs outside IDLE and restarts from 0 on leaving IDLE.
   always_comb begin
      presc_d = presc_q;
      if (!enable) begin
         presc_d = '0;
      end else if (state_q != StIdle) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end
   end

   // Next-state logic: disable beats encoder activity, which beats tick events.
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      pause_cnt_d = pause_cnt_q;
      idx_d       = idx_q;
      step_en     = 1'b0;
      if (!enable) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StFade;
            end
            StFade: begin
               if (manual_active) begin
                  state_d     = StPause;
                  pause_cnt_d = '0;
               end else if (tick && !blocked) begin
                  if (at_target) begin
                     state_d    = StHold;
                     hold_cnt_d = '0;
                  end else begin
                     step_en = 1'b1;
                  end
               end
            end
            StHold: begin
               if (manual_active) begin
                  state_d     = StPause;
                  pause_cnt_d = '0;
               end else if (tick) begin
                  if (hold_cnt_q == HW'(HOLD_TICKS - 1)) begin
                     idx_d   = idx_q + AW'(1);
                     state_d = StFade;
                  end else begin
                     hold_cnt_d = hold_cnt_q + HW'(1);
                  end
               end
            end
            StPause: begin
               if (manual_active) begin
                  pause_cnt_d = '0;
               end else if (tick) begin
                  if (pause_cnt_q == PCW'(PAUSE_TICKS - 1)) begin
                     state_d = StFade;
                  end else begin
                     pause_cnt_d = pause_cnt_q + PCW'(1);
                  end
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // Colour and handshake: a step always changes the colour, so it always raises valid.
   always_comb begin
      hue_d   = hue_q;
      sat_d   = sat_q;
      val_d   = val_q;
      valid_d = valid_q;
      if (step_en) begin
         hue_d   = hue_nxt;
         sat_d   = sat_nxt;
         val_d   = val_nxt;
         valid_d = 1'b1;
      end else if (valid_q && hsv_ready) begin
         valid_d = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         presc_q     <= '0;
         hold_cnt_q  <= '0;
         pause_cnt_q <= '0;
         idx_q       <= '0;
         hue_q       <= '0;
         sat_q       <= '0;
         val_q       <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         hold_cnt_q  <= hold_cnt_d;
         pause_cnt_q <= pause_cnt_d;
         idx_q       <= idx_d;
         hue_q       <= hue_d;
         sat_q       <= sat_d;
         val_q       <= val_d;
         valid_q     <= valid_d;
      end
   end

   assign hsv_out   = {hue_q, sat_q, val_q};
   assign hsv_valid = valid_q;
   assign scene_idx = idx_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_hsv_scene_sequencer.sv
// Bench for hsv_scene_sequencer: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hsv_scene_sequencer;

   localparam int NS = 4;
   localparam int CW = 8;
   localparam int SD = 4;
   localparam int HT = 2;
   localparam int PT = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        enable = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = '0;
   logic [23:0] cfg_data = '0;
   logic        manual_active = 1'b0;
   logic        hsv_ready = 1'b0;
   logic [23:0] hsv_out;
   logic        hsv_valid;
   logic [1:0]  scene_idx;
   logic        busy;

   always #5 clk = ~clk;

   hsv_scene_sequencer #(
      .NUM_SCENES (NS),
      .CW         (CW),
      .STEP_DIV   (SD),
      .HOLD_TICKS (HT),
      .PAUSE_TICKS(PT)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_data     (cfg_data),
      .manual_active(manual_active),
      .hsv_out      (hsv_out),
      .hsv_valid    (hsv_valid),
      .hsv_ready    (hsv_ready),
      .scene_idx    (scene_idx),
      .busy         (busy)
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   int cyc_cnt = 0;
   logic [23:0] beats[$];
   int          beat_t[$];

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum int {MIdle, MFade, MHold, MPause} mmode_t;
   mmode_t m_mode;
   int     m_run;          // cycles spent running since leaving IDLE
   int     m_hold_ticks;   // ticks completed while dwelling
   int     m_pause_ticks;  // ticks completed since the last encoder pulse
   int     m_cur[3];
   int     m_tab[NS][3];
   int     m_idx;
   bit     m_valid;

   function automatic int toward(input int c, input int t);
      if (t > c) return c + 1;
      if (t < c) return c - 1;
      return c;
   endfunction

   function automatic int hue_toward(input int c, input int t);
      int d;
      d = (t - c + 256) % 256;
      if (d == 0) return c;
      if (d <= 128) return (c + 1) % 256;
      return (c + 255) % 256;
   endfunction

   task automatic m_reset();
      m_mode = MIdle;
      m_run = 0;
      m_hold_ticks = 0;
      m_pause_ticks = 0;
      m_idx = 0;
      m_valid = 1'b0;
      for (int i = 0; i < 3; i++) m_cur[i] = 0;
      for (int s = 0; s < NS; s++) for (int i = 0; i < 3; i++) m_tab[s][i] = 0;
   endtask

   task automatic m_edge();
      bit tick, acc, blk, stepped;
      int tgt[3];
      tick = (m_mode != MIdle) && (m_run % SD == SD - 1);
      acc = m_valid && hsv_ready;
      blk = m_valid && !hsv_ready;
      stepped = 1'b0;
      for (int i = 0; i < 3; i++) tgt[i] = m_tab[m_idx][i];
      if (!enable) begin
         m_mode = MIdle;
         m_run = 0;
      end else if (m_mode == MIdle) begin
         m_mode = MFade;
      end else begin
         m_run++;
         if (manual_active) begin
            m_mode = MPause;
            m_pause_ticks = 0;
         end else if (tick) begin
            case (m_mode)
               MFade: if (!blk) begin
                  if (m_cur[0] == tgt[0] && m_cur[1] == tgt[1] && m_cur[2] == tgt[2]) begin
                     m_mode = MHold;
                     m_hold_ticks = 0;
                  end else begin
                     m_cur[0] = hue_toward(m_cur[0], tgt[0]);
                     m_cur[1] = toward(m_cur[1], tgt[1]);
                     m_cur[2] = toward(m_cur[2], tgt[2]);
                     stepped = 1'b1;
                  end
               end
               MHold: begin
                  m_hold_ticks++;
                  if (m_hold_ticks == HT) begin
                     m_idx = (m_idx + 1) % NS;
                     m_mode = MFade;
                  end
               end
               MPause: begin
                  m_pause_ticks++;
                  if (m_pause_ticks == PT) m_mode = MFade;
               end
               default: ;
            endcase
         end
      end
      if (stepped) m_valid = 1'b1;
      else if (acc) m_valid = 1'b0;
      if (cfg_we) begin
         m_tab[cfg_addr][0] = int'(cfg_data[23:16]);
         m_tab[cfg_addr][1] = int'(cfg_data[15:8]);
         m_tab[cfg_addr][2] = int'(cfg_data[7:0]);
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m_reset();
      else m_edge();
   end

   // Compare process: outputs are registered, so sample on the falling edge.
   always @(negedge clk) begin
      if (chk_en && reset_n) begin
         check("hsv_out", int'(hsv_out), (m_cur[0] << 16) | (m_cur[1] << 8) | m_cur[2]);
         check("hsv_valid", int'(hsv_valid), int'(m_valid));
         check("scene_idx", int'(scene_idx), m_idx);
         check("busy", int'(busy), int'(m_mode != MIdle));
         if (hsv_valid && hsv_ready) begin
            beats.push_back(hsv_out);
            beat_t.push_back(cyc_cnt);
         end
      end
      cyc_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [23:0] d);
      cfg_we = 1'b1;
      cfg_addr = a[1:0];
      cfg_data = d;
      cyc();
      cfg_we = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp1[5];
      int exp2[12];
      int nchg, nlow;
      logic [23:0] prev;
      exp1 = '{24'h010100, 24'h020200, 24'h030200, 24'h040200, 24'h050200};
      exp2 = '{'hFF, 'hFE, 'hFF, 'h00, 'h01, 'h02, 'h01, 'h00, 'hFF, 'hFE, 'hFF, 'h00};

      #2 reset_n = 1'b0;
      cyc();
      cyc();
      reset_n = 1'b1;
      chk_en = 1'b1;
      check("rst_hsv_out", int'(hsv_out), 0);
      check("rst_valid", int'(hsv_valid), 0);
      check("rst_idx", int'(scene_idx), 0);
      check("rst_busy", int'(busy), 0);

      // Fade from black to scene 0, one beat per tick.
      wr(0, 24'h050200);
      enable = 1'b1;
      hsv_ready = 1'b1;
      beats.delete();
      beat_t.delete();
      for (int i = 0; i < 200 && beats.size() < 5; i++) cyc();
      check("t1_nbeats", beats.size(), 5);
      for (int i = 0; i < beats.size() && i < 5; i++) check("t1_beat", int'(beats[i]), exp1[i]);
      for (int i = 1; i < beat_t.size() && i < 5; i++)
         check("t1_spacing", beat_t[i] - beat_t[i-1], SD);

      // Hue wrap in both directions and the half-circle tie going upward.
      enable = 1'b0;
      do_reset();
      wr(0, 24'hFE0000);
      wr(1, 24'h020000);
      wr(2, 24'hFE0000);
      wr(3, 24'h7E0000);
      enable = 1'b1;
      beats.delete();
      beat_t.delete();
      for (int i = 0; i < 600 && beats.size() < 12; i++) cyc();
      check("t2_nbeats", beats.size(), 12);
      for (int i = 0; i < beats.size() && i < 12; i++) check("t2_hue", int'(beats[i][23:16]), exp2[i]);

      // Disable mid-fade: idle next edge, colour and scene held.
      enable = 1'b0;
      cyc();
      check("dis_busy", int'(busy), 0);
      check("dis_hsv_out", int'(hsv_out), 0);
      check("dis_idx", int'(scene_idx), 3);
      enable = 1'b1;
      cyc();
      cyc();

      // Backpressure for 12 clk: exactly one step lands, the rest are dropped.
      hsv_ready = 1'b0;
      prev = hsv_out;
      nchg = 0;
      repeat (12) begin
         cyc();
         if (hsv_out !== prev) nchg++;
         prev = hsv_out;
      end
      check("t3_one_step", nchg, 1);
      check("t3_valid_held", int'(hsv_valid), 1);
      hsv_ready = 1'b1;
      cyc();
      cyc();

      // Encoder pulse: no steps for the pause window, still busy.
      manual_active = 1'b1;
      prev = hsv_out;
      cyc();
      manual_active = 1'b0;
      nchg = 0;
      nlow = 0;
      if (hsv_out !== prev) nchg++;
      repeat (12) begin
         cyc();
         if (hsv_out !== prev) nchg++;
         if (!busy) nlow++;
      end
      check("t4_no_step", nchg, 0);
      check("t4_busy", nlow, 0);

      // Asynchronous reset between edges clears outputs at once.
      reset_n = 1'b0;
      #1;
      check("arst_hsv_out", int'(hsv_out), 0);
      check("arst_valid", int'(hsv_valid), 0);
      check("arst_idx", int'(scene_idx), 0);
      check("arst_busy", int'(busy), 0);
      cyc();
      reset_n = 1'b1;

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         enable = ($urandom_range(0, 199) != 0);
         hsv_ready = ($urandom_range(0, 9) < 7);
         manual_active = ($urandom_range(0, 59) == 0);
         cfg_we = ($urandom_range(0, 24) == 0);
         cfg_addr = 2'($urandom_range(0, 3));
         cfg_data = {8'($urandom), 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))};
         cyc();
      end
      cfg_we = 1'b0;
      manual_active = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
